// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan_mux_nx1 display channel selector.
// Mode encodings, FSM state codes and default geometry.
package scan_mux_pkg;

  localparam int unsigned N_CH_DEF  = 11;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DIV_W_DEF = 16;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_MANUAL = 2'd0;
  localparam state_t ST_SCAN   = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

endpackage

// File: rtl/scan_tick_gen.sv
// Reloadable prescaler: tick_c fires when the count reaches div, then the count restarts.
// A count already past a freshly lowered div fires immediately.
module scan_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c = en && (cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scan_mux_nx1.sv
// Registered N:1 channel selector with manual select and round-robin auto-scan.
// Define SCAN_BLANK_EN to insert one BLANK_VAL cycle before every auto-scan advance.
module scan_mux_nx1
  import scan_mux_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DIV_W = DIV_W_DEF,
`ifdef SCAN_BLANK_EN
  parameter logic [DW-1:0] BLANK_VAL = {DW{1'b1}},
`endif
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*DW-1:0] x_flat,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              hold,
  input  logic [DIV_W-1:0]  tick_div,
  output logic [DW-1:0]     y,
  output logic [SEL_W-1:0]  sel_out,
  output logic              y_valid,
  output logic              scan_wrap
);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] idx_nxt;
  logic [SEL_W-1:0] idx_inc;
  logic             at_last;
  logic             sel_ok;
  logic             wrap_nxt;
  logic             tick;
  logic             presc_en;
  logic [DW-1:0]    y_mux;
`ifdef SCAN_BLANK_EN
  logic             blank_pend;
  logic             blank_nxt;
`endif

  assign idx     = sel_out;
  assign at_last = (idx == SEL_W'(N_CH - 1));
  assign idx_inc = at_last ? '0 : idx + SEL_W'(1);
  assign sel_ok  = ({1'b0, sel_in} < (SEL_W + 1)'(N_CH));

`ifdef SCAN_BLANK_EN
  assign presc_en = (state == ST_SCAN) && !blank_pend;
`else
  assign presc_en = (state == ST_SCAN);
`endif

  scan_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_MANUAL),
    .en     (presc_en),
    .div    (tick_div),
    .tick_c (tick)
  );

  // State follows mode/hold with one cycle of latency.
  always_comb begin
    state_nxt = ST_MANUAL;
    case (mode)
      MODE_SCAN:   state_nxt = hold ? ST_HOLD : ST_SCAN;
      MODE_MANUAL: state_nxt = ST_MANUAL;
      default:     state_nxt = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_MANUAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next index; the data mux looks at it so y and sel_out update together.
  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_nxt = 1'b0;
`endif
    case (state)
      ST_MANUAL: idx_nxt = sel_ok ? sel_in : '0;
      ST_SCAN: begin
        if (tick) begin
`ifdef SCAN_BLANK_EN
          blank_nxt = 1'b1;
`else
          idx_nxt  = idx_inc;
          wrap_nxt = at_last;
`endif
        end
      end
      default: ;
    endcase
`ifdef SCAN_BLANK_EN
    // Blank cycle is over: commit the deferred advance unless manual took over.
    if (blank_pend && (state != ST_MANUAL)) begin
      idx_nxt  = idx_inc;
      wrap_nxt = at_last;
    end
`endif
  end

  always_comb begin
    y_mux = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx_nxt == SEL_W'(k)) y_mux = x_flat[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      sel_out   <= '0;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
`ifdef SCAN_BLANK_EN
      blank_pend <= 1'b0;
`endif
    end else begin
      sel_out   <= idx_nxt;
      y_valid   <= (idx_nxt != idx);
      scan_wrap <= wrap_nxt;
`ifdef SCAN_BLANK_EN
      blank_pend <= blank_nxt;
      y          <= blank_nxt ? BLANK_VAL : y_mux;
`else
      y          <= y_mux;
`endif
    end
  end

endmodule

// File: tb/tb_scan_mux_nx1.sv
// Directed bench for scan_mux_nx1 in its default build (11 x 8-bit channels).
module tb_scan_mux_nx1;

  localparam int unsigned N_CH  = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned SEL_W = 4;

  logic               clk;
  logic               rst_n;
  logic [N_CH*DW-1:0] x_flat;
  logic               mode;
  logic [SEL_W-1:0]   sel_in;
  logic               hold;
  logic [DIV_W-1:0]   tick_div;
  logic [DW-1:0]      y;
  logic [SEL_W-1:0]   sel_out;
  logic               y_valid;
  logic               scan_wrap;

  int n_chk  = 0;
  int n_pass = 0;

  scan_mux_nx1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_flat    (x_flat),
    .mode      (mode),
    .sel_in    (sel_in),
    .hold      (hold),
    .tick_div  (tick_div),
    .y         (y),
    .sel_out   (sel_out),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    x_flat[k*DW +: DW] = v;
  endtask

  initial begin
    rst_n    = 1'b0;
    mode     = 1'b0;
    sel_in   = '0;
    hold     = 1'b0;
    tick_div = '0;
    for (int k = 0; k < N_CH; k++) set_ch(k, 8'(8'h40 + k));
    set_ch(3, 8'hA5);
    step();
    step();
    chk("rst_y", y, 0);
    chk("rst_sel", sel_out, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_wrap", scan_wrap, 0);

    // Manual select of channel 3.
    rst_n  = 1'b1;
    sel_in = 4'd3;
    step();
    chk("man3_y", y, 8'hA5);
    chk("man3_sel", sel_out, 3);
    chk("man3_valid", y_valid, 1);
    step();
    chk("man3_valid_drop", y_valid, 0);
    chk("man3_y_hold", y, 8'hA5);

    // Out-of-range select falls back to channel 0.
    sel_in = 4'hC;
    step();
    chk("oor_y", y, 8'h40);
    chk("oor_sel", sel_out, 0);
    chk("oor_valid", y_valid, 1);

    // Auto-scan, tick_div=2: advance every 3 edges once in ST_SCAN.
    for (int k = 0; k < N_CH; k++) set_ch(k, 8'(k));
    sel_in = 4'd0;
    step();
    chk("pre_scan_y", y, 0);
    mode     = 1'b1;
    tick_div = 16'd2;
    step();
    chk("scan_start_sel", sel_out, 0);
    for (int k = 1; k <= N_CH; k++) begin
      step();
      step();
      chk("scan_wait_sel", sel_out, (k - 1) % N_CH);
      chk("scan_wait_wrap", scan_wrap, 0);
      step();
      chk("scan_sel", sel_out, k % N_CH);
      chk("scan_y", y, k % N_CH);
      chk("scan_valid", y_valid, 1);
      chk("scan_wrap", scan_wrap, (k == N_CH) ? 1 : 0);
    end
    step();
    chk("wrap_pulse_end", scan_wrap, 0);
    chk("valid_pulse_end", y_valid, 0);

    // Park on channel 5 manually, then hold in auto mode while x5 changes.
    mode   = 1'b0;
    sel_in = 4'd5;
    step();
    step();
    chk("park_sel", sel_out, 5);
    chk("park_valid", y_valid, 1);
    mode = 1'b1;
    hold = 1'b1;
    set_ch(5, 8'h11);
    step();
    step();
    chk("hold_y11", y, 8'h11);
    set_ch(5, 8'h22);
    step();
    chk("hold_y22", y, 8'h22);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_sel", sel_out, 5);
      chk("hold_valid", y_valid, 0);
    end

    // tick_div=0 scanning, then asynchronous reset at index 7.
    tick_div = 16'd0;
    hold     = 1'b0;
    step();
    chk("resume_sel", sel_out, 5);
    step();
    chk("fast_sel6", sel_out, 6);
    step();
    chk("fast_sel7", sel_out, 7);
    chk("fast_y7", y, 7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 0);
    chk("async_rst_sel", sel_out, 0);
    step();
    sel_in = 4'd0;
    rst_n  = 1'b1;
    step();
    chk("post_rst_sel0", sel_out, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("post_rst_sel", sel_out, k);
      chk("post_rst_y", y, k);
      chk("post_rst_valid", y_valid, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_mux_nx1.md
Name: scan_mux_nx1

Overview:
- Parametrised, registered N:1 channel selector; successor to the fixed 11-input 8-bit combinational mux.
- Adds an auto-scan mode: an internal prescaler steps the selected channel round-robin. This is used for time-multiplexed digit/segment display driving.
- Keeps the manual mode, with a one-cycle registered latency.
- Sits between the display data formatters and the display driver.

Parameters:
- N_CH, 11, number of input channels (2..16).
- DW, 8, width of each channel in bits.
- DIV_W, 16, width of the scan prescaler reload value.
- SEL_W, $clog2(N_CH), localparam, width of the select index.
- BLANK_VAL, {DW{1'b1}}, value driven during the blanking cycle (only with SCAN_BLANK_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_flat  in  N_CH*DW  packed channels; channel k occupies bits [k*DW +: DW].
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel_in  in  SEL_W  channel index used in manual mode.
- hold  in  1  in auto-scan, freezes the index and the prescaler.
- tick_div  in  DIV_W  prescaler reload; the index advances every tick_div+1 cycles.
- y  out  DW  registered selected data.
- sel_out  out  SEL_W  index currently driven on y.
- y_valid  out  1  one-cycle pulse when sel_out changes.
- scan_wrap  out  1  one-cycle pulse when the auto-scan index wraps from N_CH-1 to 0.

Behaviour:
- Reset (async assert, sync release): y=0, sel_out=0, y_valid=0, scan_wrap=0, prescaler=0, index=0, FSM=ST_MANUAL.
- FSM states:
  - ST_MANUAL: entered when mode=0, from any state.
  - ST_SCAN: mode=1 and hold=0.
  - ST_HOLD: mode=1 and hold=1.
  - The state is re-evaluated every cycle from mode/hold; transitions take one cycle.
- ST_MANUAL:
  - index <= sel_in when sel_in < N_CH; otherwise index <= 0, the same as the legacy default branch.
  - y <= x_flat[index], so y reflects sel_in one cycle later.
  - The prescaler is held at 0.
- ST_SCAN:
  - The prescaler counts 0..tick_div.
  - On reaching tick_div: prescaler <= 0 and index <= index+1.
  - If index == N_CH-1, index <= 0 and scan_wrap pulses in the same cycle as the wrap is registered.
  - tick_div=0 advances the index every cycle.
- ST_HOLD: index and prescaler are frozen. y still refreshes from x_flat[index] every cycle, so live data tracks.
- Mode switch manual->auto: scanning starts from the current index; the prescaler restarts at 0.
- Mode switch auto->manual: sel_in takes effect on the next edge; the prescaler is cleared.
- y always equals x_flat[sel_out] as sampled on the previous edge. Data changes on the selected channel propagate with 1-cycle latency.
- y_valid pulses for one cycle whenever the registered sel_out differs from its previous value. It never pulses while the index is unchanged.
- If tick_div changes mid-count: when the prescaler is already >= the new tick_div, it advances on the next cycle and resets to 0.
- If rst_n is asserted mid-scan: all outputs return to reset values immediately.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - In ST_SCAN, each index advance first drives y=BLANK_VAL for one cycle. This is anti-ghosting for multiplexed 7-seg displays.
  - The new channel data follows on the next cycle.
  - sel_out updates with the data, not with the blank.
  - y_valid is delayed one cycle to coincide with the data.
  - There is no blanking in ST_MANUAL or ST_HOLD.
- Undefined: no blank cycle; the behaviour is exactly as above.

Decomposition:
- Package scan_mux_pkg:
  - mode encodings MODE_MANUAL/MODE_SCAN.
  - FSM state typedef (ST_MANUAL, ST_SCAN, ST_HOLD).
  - Default DW/N_CH constants.
- Sub-module scan_tick_gen: DIV_W prescaler with clear/enable inputs and a tick output. It is reused by other display blocks.

Test Plan:
- Reset, then mode=0, sel_in=3, x3=8'hA5: one cycle later y=8'hA5, sel_out=3, y_valid=1 for one cycle.
- Manual, sel_in=4'hC with N_CH=11: y=x0, sel_out=0.
- mode=1, tick_div=2, x_k=k: the index advances every 3 cycles through 0..10. At the 10->0 step scan_wrap=1 for exactly one cycle, and y follows 0,1,…,10,0.
- Auto with hold=1 for 10 cycles while x5 changes 8'h11->8'h22: sel_out stays 5, y updates to 8'h22 after one cycle, no y_valid.
- tick_div=0 with rst_n asserted mid-scan at index 7: y=0, sel_out=0 immediately. After release, scanning resumes from 0 at one channel per cycle.
- With SCAN_BLANK_EN: each advance shows y=8'hFF for one cycle, then the data; y_valid aligns with the data cycle.
